// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester byte arbiter for a UART transmitter with message locking and inter-byte gap
module uart_tx_arb #(
    parameter int GAP_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_busy,
    output logic [7:0] dataout,
    output logic       wrsig,
    output logic       owner,
    output logic       arb_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    localparam logic [7:0] GAP_MAX = 8'(GAP_CYCLES - 1);
    state_t     r_state, w_next;
    logic       r_lock, r_lock_id, r_last_grant, r_wrsig, r_owner;
    logic [7:0] r_gap, r_dataout;
    logic       w_idle, w_sel, w_grant, w_sel_last, w_gap_done;
    logic [7:0] w_sel_data;

    // selection: lock owner only while locked, otherwise sole valid requester or the one not granted last
    always_comb begin
        w_idle     = (r_state == IDLE) && rst_n;
        w_sel      = r_lock ? r_lock_id : (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_grant    = w_idle && (w_sel ? req1_valid : req0_valid);
        w_sel_data = w_sel ? req1_data : req0_data;
        w_sel_last = w_sel ? req1_last : req0_last;
        req0_ready = w_grant && !w_sel;
        req1_ready = w_grant && w_sel;
    end

    // next state: accept in IDLE, strobe once in ISSUE, wait out gap and transmitter in HOLD
    always_comb begin
        w_gap_done = (r_gap == GAP_MAX);
        w_next     = r_state;
        if (r_state == IDLE && w_grant) w_next = ISSUE;
        if (r_state == ISSUE) w_next = HOLD;
        if (r_state == HOLD && w_gap_done && !tx_busy) w_next = IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // accepted byte capture, strobe, lock tracking and saturating gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrsig      <= 1'b0;
            r_dataout    <= 8'h00;
            r_owner      <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_id    <= 1'b0;
            r_last_grant <= 1'b1;
            r_gap        <= 8'd0;
        end else begin
            r_wrsig <= w_grant;
            r_gap   <= (r_state == HOLD) ? (w_gap_done ? r_gap : r_gap + 8'd1) : 8'd0;
            if (w_grant) begin
                r_dataout    <= w_sel_data;
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
                r_lock       <= !w_sel_last;
                r_lock_id    <= w_sel;
            end
        end
    end

    assign dataout  = r_dataout;
    assign wrsig    = r_wrsig;
    assign owner    = r_owner;
    assign arb_busy = (r_state != IDLE);
endmodule
